// File: rtl/video_shifter.sv
// -----------------------------------------------------------------------------
// video_shifter
//
// Serialises 16-bit screen words into a one-pixel-per-clock stream. Words
// arrive through a one-word holding register and are moved into the shift
// register as its last bit goes out, so back-to-back words are gapless.
// The display-enable (from the blanking inputs) and both syncs travel through
// one SYNC_DELAY-deep pipeline, which keeps them aligned with each other.
//
// Parameters
//   INVERT      : XORed into every shifted bit (1 = Mac "1 is black").
//   BLANK_LEVEL : pixel value while not displaying or when starved.
//   SYNC_DELAY  : clk delay of de/hsync_o/vsync_o, 1..31.
//
// Ports
//   clk         in   pixel clock, one pixel per cycle
//   _reset      in   asynchronous active-low reset
//   clk_en      in   bus-rate enable (one clk in four)
//   loadPixels  in   word-fetch strobe, qualified by clk_en
//   dataIn      in   screen word, valid when clk_en && loadPixels
//   _hblank     in   active-low horizontal blanking
//   _vblank     in   active-low vertical blanking
//   hsync       in   horizontal sync from the video timer
//   vsync       in   vertical sync from the video timer
//   clear_err   in   synchronous clear of the sticky error flags
//   pixel       out  registered serial pixel, MSB of each word first
//   de          out  delayed display enable
//   hsync_o     out  delayed hsync
//   vsync_o     out  delayed vsync
//   overrun     out  sticky: a held word was overwritten before use
//   underrun    out  sticky: display active with the shifter empty
// -----------------------------------------------------------------------------
module video_shifter #(
    parameter bit INVERT      = 1'b1,
    parameter bit BLANK_LEVEL = 1'b0,
    parameter int SYNC_DELAY  = 8
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk_en,
    input  logic        loadPixels,
    input  logic [15:0] dataIn,
    input  logic        _hblank,
    input  logic        _vblank,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        clear_err,
    output logic        pixel,
    output logic        de,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        overrun,
    output logic        underrun
);

    logic [15:0] hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  bits_left_q, bits_left_d;
    logic        pixel_q, pixel_d;
    logic        overrun_q, overrun_d;
    logic        underrun_q, underrun_d;

    logic [SYNC_DELAY-1:0] act_pipe_q, act_pipe_d;
    logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

    logic capture;
    logic transfer;
    logic active;
    logic overrun_ev;
    logic underrun_ev;

    // Delay pipeline: stage 0 samples the inputs, each later stage copies
    // its predecessor. Written per stage so SYNC_DELAY=1 needs no special case.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_DELAY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign act_pipe_d[gi] = _hblank & _vblank;
                assign hs_pipe_d[gi]  = hsync;
                assign vs_pipe_d[gi]  = vsync;
            end else begin : g_tail
                assign act_pipe_d[gi] = act_pipe_q[gi-1];
                assign hs_pipe_d[gi]  = hs_pipe_q[gi-1];
                assign vs_pipe_d[gi]  = vs_pipe_q[gi-1];
            end
        end
    endgenerate

    assign active = act_pipe_q[SYNC_DELAY-1];

    always_comb begin
        capture  = clk_en & loadPixels;
        // Reload as the final bit is being shown, so the next word's MSB
        // follows on the very next clock.
        transfer = hold_valid_q & (bits_left_q <= 5'd1);

        overrun_ev  = capture & hold_valid_q & ~transfer;
        underrun_ev = active & (bits_left_q == 5'd0);

        // A transfer reads the old hold while a same-cycle capture refills it.
        hold_d       = capture ? dataIn : hold_q;
        hold_valid_d = capture | (hold_valid_q & ~transfer);

        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        if (transfer) begin
            shreg_d     = hold_q;
            bits_left_d = 5'd16;
        end else if (bits_left_q != 5'd0) begin
            shreg_d     = {shreg_q[14:0], 1'b0};
            bits_left_d = bits_left_q - 5'd1;
        end

        pixel_d = (active && (bits_left_q != 5'd0)) ? (shreg_q[15] ^ INVERT) : BLANK_LEVEL;

        // A new event in the clearing cycle wins, leaving the flag set.
        overrun_d  = (overrun_q & ~clear_err) | overrun_ev;
        underrun_d = (underrun_q & ~clear_err) | underrun_ev;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            bits_left_q  <= '0;
            pixel_q      <= BLANK_LEVEL;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            act_pipe_q   <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            bits_left_q  <= bits_left_d;
            pixel_q      <= pixel_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
            act_pipe_q   <= act_pipe_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
        end
    end

    assign pixel    = pixel_q;
    assign de       = active;
    assign hsync_o  = hs_pipe_q[SYNC_DELAY-1];
    assign vsync_o  = vs_pipe_q[SYNC_DELAY-1];
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_video_shifter.sv
// -----------------------------------------------------------------------------
// tb_video_shifter
//
// Directed stimulus for video_shifter with its default parameters. A
// behavioural model (a queue of pending pixel bits, one pending word and
// SYNC_DELAY-long history arrays for the delayed signals) predicts every
// output; each clock the outputs are compared against it at the falling edge.
// Hand-computed literal expectations pin the model for the key scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_shifter;

    localparam int D     = 8;
    localparam bit INV   = 1'b1;
    localparam bit BLANK = 1'b0;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        clk_en   = 1'b0;
    logic        load_px  = 1'b0;
    logic [15:0] din      = 16'h0000;
    logic        hb       = 1'b0;
    logic        vb       = 1'b1;
    logic        hs       = 1'b1;
    logic        vs       = 1'b1;
    logic        clr      = 1'b0;

    logic pixel, de, hsync_o, vsync_o, overrun, underrun;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    bit cmp_en   = 1'b0;

    video_shifter #(
        .INVERT      (INV),
        .BLANK_LEVEL (BLANK),
        .SYNC_DELAY  (D)
    ) dut (
        .clk        (clk),
        ._reset     (rst_n),
        .clk_en     (clk_en),
        .loadPixels (load_px),
        .dataIn     (din),
        ._hblank    (hb),
        ._vblank    (vb),
        .hsync      (hs),
        .vsync      (vs),
        .clear_err  (clr),
        .pixel      (pixel),
        .de         (de),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // ---------------- behavioural model ----------------
    logic        m_act [D];
    logic        m_hs  [D];
    logic        m_vs  [D];
    bit          m_q[$];          // pixel bits still to be shown, MSB first
    logic [15:0] m_pend;
    bit          m_pend_v = 1'b0;
    logic        m_pix    = BLANK;
    logic        m_ovr    = 1'b0;
    logic        m_unr    = 1'b0;
    bit          m_a, m_x, m_oev, m_uev;

    initial begin
        for (int i = 0; i < D; i++) begin
            m_act[i] = 1'b0;
            m_hs[i]  = 1'b1;
            m_vs[i]  = 1'b1;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_pend_v = 1'b0;
                m_pix    = BLANK;
                m_ovr    = 1'b0;
                m_unr    = 1'b0;
                for (int i = 0; i < D; i++) begin
                    m_act[i] = 1'b0;
                    m_hs[i]  = 1'b1;
                    m_vs[i]  = 1'b1;
                end
            end else begin
                m_a   = m_act[D-1];
                m_uev = m_a && (m_q.size() == 0);
                m_pix = (m_a && m_q.size() > 0) ? (m_q[0] ^ INV) : BLANK;
                // pending word joins the stream when at most one bit remains
                m_x   = m_pend_v && (m_q.size() <= 1);
                m_oev = clk_en && load_px && m_pend_v && !m_x;
                if (m_q.size() > 0) void'(m_q.pop_front());
                if (m_x) begin
                    for (int b = 15; b >= 0; b--) m_q.push_back(m_pend[b]);
                    m_pend_v = 1'b0;
                end
                if (clk_en && load_px) begin
                    m_pend   = din;
                    m_pend_v = 1'b1;
                end
                m_ovr = (m_ovr && !clr) || m_oev;
                m_unr = (m_unr && !clr) || m_uev;
                for (int i = D-1; i > 0; i--) begin
                    m_act[i] = m_act[i-1];
                    m_hs[i]  = m_hs[i-1];
                    m_vs[i]  = m_vs[i-1];
                end
                m_act[0] = hb && vb;
                m_hs[0]  = hs;
                m_vs[0]  = vs;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: inputs already set by the caller at a falling edge; the
    // outputs are compared against the model at the next falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (cmp_en) begin
            chk1("model_pixel", pixel, m_pix);
            chk1("model_de", de, m_act[D-1]);
            chk1("model_hsync_o", hsync_o, m_hs[D-1]);
            chk1("model_vsync_o", vsync_o, m_vs[D-1]);
            chk1("model_overrun", overrun, m_ovr);
            chk1("model_underrun", underrun, m_unr);
        end
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    // One bus slot: clk_en for one clk, then three clk without.
    task automatic bus(input logic ld, input logic [15:0] d);
        clk_en  = 1'b1;
        load_px = ld;
        din     = d;
        cyc();
        clk_en  = 1'b0;
        load_px = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] got;
    int          low_cnt, fall_edge, launch_edge, run, max_run, ones;

    initial begin
        @(negedge clk);
        repeat (3) cyc();

        // ---- reset state ----
        chk1("rst_pixel", pixel, BLANK);
        chk1("rst_de", de, 1'b0);
        chk1("rst_hsync_o", hsync_o, 1'b1);
        chk1("rst_vsync_o", vsync_o, 1'b1);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        repeat (12) cyc();
        $display("reset released, idle done");

        // ---- single word A5F0, first pixel two clocks after capture ----
        hb = 1'b1;
        repeat (D + 2) cyc();
        clk_en = 1'b1; load_px = 1'b1; din = 16'hA5F0;
        cyc();                                   // capture edge N
        clk_en = 1'b0; load_px = 1'b0;
        cyc();                                   // N+1: transfer
        for (int i = 0; i < 16; i++) begin
            clr = (i == 0);                      // drop the pre-word underrun
            cyc();                               // N+2+i
            got[15-i] = pixel;
        end
        clr = 1'b0;
        chk("seq_a5f0", 32'(got), 32'h5A0F);
        chk1("unr_clear_mid_word", underrun, 1'b0);
        $display("word A5F0 -> pixels %h", got);

        // ---- starvation: underrun set, pixel blank, sticky ----
        cyc();
        chk1("unr_set", underrun, 1'b1);
        chk1("unr_pixel_blank", pixel, BLANK);
        repeat (19) cyc();
        chk1("unr_after_20", underrun, 1'b1);
        clear_flags();                           // starvation still ongoing
        chk1("clr_prio_unr", underrun, 1'b1);
        hb = 1'b0;
        repeat (D + 2) cyc();
        chk1("unr_persist", underrun, 1'b1);
        clear_flags();
        chk1("unr_cleared", underrun, 1'b0);
        $display("underrun set, persisted, cleared");

        // ---- sync delay: 17-clk hsync pulse, 5-clk vsync pulse ----
        launch_edge = edge_cnt;
        fall_edge   = -1;
        low_cnt     = 0;
        for (int t = 0; t < 40; t++) begin
            hs = (t < 17) ? 1'b0 : 1'b1;
            vs = (t >= 3 && t < 8) ? 1'b0 : 1'b1;
            cyc();
            if (!hsync_o) begin
                low_cnt++;
                if (fall_edge < 0) fall_edge = edge_cnt;
            end
        end
        chk("hs_low_len", 32'(low_cnt), 32'd17);
        chk("hs_delay", 32'(fall_edge - launch_edge), 32'(D));
        $display("hsync_o low %0d clk, delay %0d", low_cnt, fall_edge - launch_edge);

        // ---- overrun: second word overwrites the first held word ----
        hb = 1'b1;
        repeat (D + 2) cyc();
        bus(1'b1, 16'hFFFF);                     // N: goes straight to shreg
        bus(1'b1, 16'h0000);                     // N+4: held
        chk1("ovr_none_yet", overrun, 1'b0);
        clk_en = 1'b1; load_px = 1'b1; din = 16'h00FF;
        cyc();                                   // N+8: overwrites hold
        clk_en = 1'b0; load_px = 1'b0;
        chk1("ovr_set", overrun, 1'b1);
        repeat (9) cyc();                        // up to N+17
        for (int i = 0; i < 16; i++) begin
            cyc();                               // N+18+i
            got[15-i] = pixel;
        end
        chk("ovr_word_kept", 32'(got), 32'hFF00);
        clear_flags();
        chk1("ovr_cleared", overrun, 1'b0);
        hb = 1'b0;
        repeat (D + 2) cyc();
        clear_flags();
        $display("overrun: shown word %h", got);

        // ---- full line: 32 words, one every 16 clk ----
        hb = 1'b1;
        repeat (D - 2) cyc();                    // active rises with first pixel
        run = 0; max_run = 0; ones = 0;
        for (int c = 0; c < 520; c++) begin
            hb      = (c < 506);                 // active falls after last pixel
            clk_en  = (c % 4 == 0);
            load_px = (c % 16 == 0) && (c < 512);
            din     = 16'h0000;                  // every pixel shows as 1
            cyc();
            if (pixel) begin
                run++;
                ones++;
            end else begin
                if (run > max_run) max_run = run;
                run = 0;
            end
        end
        clk_en = 1'b0; load_px = 1'b0;
        chk("line_run", 32'(max_run), 32'd512);
        chk("line_ones", 32'(ones), 32'd512);
        chk1("line_underrun", underrun, 1'b0);
        chk1("line_overrun", overrun, 1'b0);
        $display("line: longest run %0d, total ones %0d", max_run, ones);

        // ---- reset mid-word ----
        hb = 1'b1;
        repeat (D + 2) cyc();
        clk_en = 1'b1; load_px = 1'b1; din = 16'h0000;
        cyc();                                   // N
        clk_en = 1'b0; load_px = 1'b0;
        repeat (10) cyc();                       // N+10: bitsLeft = 7
        chk1("pre_rst_pixel", pixel, 1'b1);
        chk1("pre_rst_de", de, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_pixel", pixel, BLANK);
        chk1("async_rst_de", de, 1'b0);
        chk1("async_rst_hsync_o", hsync_o, 1'b1);
        repeat (2) cyc();
        rst_n = 1'b1;
        ones = 0;
        repeat (D + 4) begin
            cyc();
            if (pixel) ones++;
        end
        chk("no_stale_pixels", 32'(ones), 32'd0);
        clk_en = 1'b1; load_px = 1'b1; din = 16'hFFFF;
        cyc();                                   // N'
        clk_en = 1'b0; load_px = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) begin
            cyc();
            got[15-i] = pixel;
        end
        chk("post_rst_ffff", 32'(got), 32'h0000);
        chk1("post_rst_de", de, 1'b1);
        $display("after reset: word FFFF -> pixels %h", got);

        hb = 1'b0;
        repeat (4) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_shifter.md
VIDEO_SHIFTER -- requirements
Module: video_shifter

Interface
REQ-001 Parameter INVERT, default 1: SHALL XOR each shifted bit before output, so Mac 1=black becomes pixel 0.
REQ-002 Parameter BLANK_LEVEL, default 0: SHALL be the pixel value driven when not displaying.
REQ-003 Parameter SYNC_DELAY, default 8, range 1..31: SHALL be the clk delay applied to de/hsync_o/vsync_o.
REQ-004 clk  in  1  system clock, one pixel per cycle.
REQ-005 _reset  in  1  asynchronous active-low reset.
REQ-006 clk_en  in  1  bus-rate enable, one cycle in four of clk.
REQ-007 loadPixels  in  1  word-fetch strobe from the video timer, qualified by clk_en.
REQ-008 dataIn  in  16  screen word, valid when clk_en&&loadPixels.
REQ-009 _hblank, _vblank  in  1 each  active-low blanking from the video timer.
REQ-010 hsync, vsync  in  1 each  syncs from the video timer.
REQ-011 clear_err  in  1  synchronous clear of sticky error flags.
REQ-012 pixel  out  1  serial pixel, MSB of each word first.
REQ-013 de, hsync_o, vsync_o  out  1 each  delayed display-enable and syncs.
REQ-014 overrun, underrun  out  1 each  sticky error flags.

Function
REQ-015 Capture: on clk with clk_en&&loadPixels, hold SHALL take dataIn and holdValid SHALL be set.
REQ-016 Shift register shreg[15:0] with bitsLeft[4:0], range 0..16; each clk with bitsLeft>0, shreg SHALL shift left one bit and bitsLeft SHALL decrement.
REQ-017 Transfer: on clk with holdValid && bitsLeft<=1, shreg SHALL take hold, bitsLeft SHALL become 16, and holdValid SHALL clear. Result: gapless 16-pixel words.
REQ-018 Simultaneous transfer and capture: transfer SHALL take the old hold; hold SHALL take the new dataIn; holdValid SHALL remain 1.
REQ-019 Overrun: capture while holdValid=1 with no transfer that cycle SHALL overwrite hold and set overrun.
REQ-020 pixel: registered; SHALL equal shreg[15]^INVERT when bitsLeft>0 && active, else BLANK_LEVEL.
REQ-021 active: SHALL be the (_hblank&&_vblank) input delayed SYNC_DELAY clk through a shift pipeline.
REQ-022 Underrun: a clk with active=1 and bitsLeft=0 SHALL set underrun; pixel SHALL be BLANK_LEVEL that cycle.
REQ-023 de, hsync_o, vsync_o: SHALL be active, hsync and vsync delayed SYNC_DELAY clk through the same pipeline, so all three stay mutually aligned.
REQ-024 Latency: the first pixel of a word captured at clk edge N, with an empty shifter, SHALL appear on pixel at edge N+2.
REQ-025 clear_err SHALL clear both flags; a same-cycle new error event SHALL take priority, leaving the flag set.
REQ-026 The block SHALL be insensitive to line length; a line of 32 words yields 512 pixels with no holdValid residue at line end.

Reset
REQ-027 While _reset=0, outputs SHALL be: pixel=BLANK_LEVEL, de=0, hsync_o=1, vsync_o=1, overrun=0, underrun=0.
REQ-028 While _reset=0, internal state SHALL be: holdValid=0, bitsLeft=0, shreg=0, and all pipeline stages at their inactive values.
REQ-029 Reset assertion mid-word SHALL discard hold and shreg immediately; no stale pixels SHALL appear after release.
REQ-030 After release, the first capture SHALL follow REQ-024 timing.

Verification
REQ-031 One capture of 16'hA5F0, active held 1, INVERT=1 -> pixel sequence from edge N+2 is 0,1,0,1,1,0,1,0,0,0,0,0,1,1,1,1.
REQ-032 32 captures every 16 clk, one per 4th clk_en -> 512 contiguous pixels with no BLANK_LEVEL gap; underrun=0; overrun=0.
REQ-033 Captures on two consecutive clk_en pulses (4 clk apart) with shreg full -> overrun=1; the second word is shifted and the first is lost. clear_err then -> overrun=0.
REQ-034 active=1 with no capture for 20 clk -> underrun=1 and pixel=BLANK_LEVEL; the flag persists until clear_err.
REQ-035 hsync low pulse of 17 clk with SYNC_DELAY=8 -> hsync_o low exactly 17 clk, starting 8 clk later.
REQ-036 _reset asserted at bitsLeft=7 -> pixel=BLANK_LEVEL, de=0 asynchronously. After release, the next capture of 16'hFFFF outputs 16 zeros at edges N+2..N+17.
